// File: rtl/mxv_pkg.sv
// Shared constants, command/state encodings and frame helpers for the MxV command path.
// Optional checksum byte support is selected by MXV_CHECKSUM_EN.
package mxv_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned MAX_N = 8;
  localparam int unsigned NW    = 4;

  localparam logic [DW-1:0] HDR  = 8'hFE;
  localparam logic [DW-1:0] TAIL = 8'hEF;

  typedef enum logic [2:0] {
    CMD_SET_N   = 3'd1,
    CMD_RESEND  = 3'd2,
    CMD_LOAD_M  = 3'd3,
    CMD_LOAD_V  = 3'd4,
    CMD_COMPUTE = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_CMD,
    ST_PAYLOAD,
    ST_TAIL,
    ST_EXEC,
    ST_WAIT_DONE
`ifdef MXV_CHECKSUM_EN
    ,
    ST_CHK
`endif
  } seq_state_e;

  // Frame length legality for a command byte, given the current dimension.
  function automatic logic len_ok(input logic [DW-1:0] cmd, input logic [DW-1:0] len,
                                  input logic [NW-1:0] n);
    logic [DW-1:0] pl;
    logic [DW-1:0] nn;
    pl = len - DW'(1);
    nn = DW'(n) * DW'(n);
    len_ok = 1'b0;
    if (cmd[DW-1:3] == '0) begin
      case (cmd[2:0])
        3'(CMD_SET_N):                 len_ok = (len == DW'(2));
        3'(CMD_RESEND), 3'(CMD_COMPUTE): len_ok = 1'b1;
        3'(CMD_LOAD_M):                len_ok = (n != '0) && (pl == nn);
        3'(CMD_LOAD_V):                len_ok = (n != '0) && (pl == DW'(n));
        default:                       len_ok = 1'b0;
      endcase
    end
  endfunction

  // Legal SET_N payload: 1..MAX_N.
  function automatic logic setn_ok(input logic [DW-1:0] v);
    setn_ok = (v != '0) && (v <= DW'(MAX_N));
  endfunction

endpackage

// File: rtl/mxv_cmd_sequencer_if.sv
// Byte/command bus between the UART receive side, the sequencer and the MxV datapath.
interface mxv_cmd_sequencer_if;
  import mxv_pkg::*;

  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          mxv_done;
  logic [2:0]    cmd_code;
  logic          cmd_valid;
  logic [NW-1:0] n_size;
  logic [DW-1:0] load_data;
  logic          load_valid;
  logic          load_sel;
  logic          start;
  logic          busy;
  logic          frame_err;

  modport master (
    input  rx_data, rx_valid, mxv_done,
    output cmd_code, cmd_valid, n_size, load_data, load_valid, load_sel,
           start, busy, frame_err
  );

  modport slave (
    output rx_data, rx_valid, mxv_done,
    input  cmd_code, cmd_valid, n_size, load_data, load_valid, load_sel,
           start, busy, frame_err
  );
endinterface

// File: rtl/mxv_rx_timeout.sv
// Inter-byte watchdog: flags expired after TIMEOUT_CYC enabled cycles without a clear.
module mxv_rx_timeout #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Count idle enabled cycles; hold at the limit once expired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) expired <= 1'b1;
      else             cnt     <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mxv_cmd_sequencer.sv
// Frame parser / controller between UART Rx and the MxV datapath.
// Frame: FE LEN CMD payload[LEN-1] [CHK when MXV_CHECKSUM_EN] EF.
module mxv_cmd_sequencer
  import mxv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  mxv_cmd_sequencer_if.master bus
);

`ifdef MXV_CHECKSUM_EN
  localparam seq_state_e ST_AFTER_PL = ST_CHK;
`else
  localparam seq_state_e ST_AFTER_PL = ST_TAIL;
`endif

  seq_state_e state, next_state;
  logic       abort_c;
  logic       expired, tmr_en, tmr_clr;

  logic [DW-1:0] len_q, len_d, rem_q, rem_d, setn_q, setn_d;
  logic [2:0]    cmd_q, cmd_d;
`ifdef MXV_CHECKSUM_EN
  logic [DW-1:0] chk_q, chk_d;
`endif

  logic [2:0]    cmd_code_q, cmd_code_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [NW-1:0] n_size_q, n_size_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic          load_valid_q, load_valid_d;
  logic          load_sel_q, load_sel_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;

  // Watchdog runs only while a frame is partially received.
  assign tmr_en  = (state == ST_LEN) || (state == ST_CMD) || (state == ST_PAYLOAD) ||
`ifdef MXV_CHECKSUM_EN
                   (state == ST_CHK) ||
`endif
                   (state == ST_TAIL);
  assign tmr_clr = bus.rx_valid || !tmr_en;

  mxv_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; abort_c marks a rejected frame.
  always_comb begin
    next_state = state;
    abort_c    = 1'b0;
    case (state)
      ST_IDLE: if (bus.rx_valid && bus.rx_data == HDR) next_state = ST_LEN;
      ST_LEN: begin
        if (expired) abort_c = 1'b1;
        else if (bus.rx_valid) begin
          if (bus.rx_data == '0) abort_c = 1'b1;
          else                   next_state = ST_CMD;
        end
      end
      ST_CMD: begin
        if (expired) abort_c = 1'b1;
        else if (bus.rx_valid) begin
          if (!len_ok(bus.rx_data, len_q, n_size_q)) abort_c = 1'b1;
          else if (len_q == DW'(1))                   next_state = ST_AFTER_PL;
          else                                        next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (expired) abort_c = 1'b1;
        else if (bus.rx_valid && rem_q == DW'(1)) next_state = ST_AFTER_PL;
      end
`ifdef MXV_CHECKSUM_EN
      ST_CHK: begin
        if (expired) abort_c = 1'b1;
        else if (bus.rx_valid) begin
          if (bus.rx_data == chk_q) next_state = ST_TAIL;
          else                      abort_c = 1'b1;
        end
      end
`endif
      ST_TAIL: begin
        if (expired) abort_c = 1'b1;
        else if (bus.rx_valid) begin
          if (bus.rx_data == TAIL && (cmd_q != CMD_SET_N || setn_ok(setn_q)))
            next_state = ST_EXEC;
          else
            abort_c = 1'b1;
        end
      end
      ST_EXEC:      next_state = (cmd_q == CMD_COMPUTE) ? ST_WAIT_DONE : ST_IDLE;
      ST_WAIT_DONE: if (bus.mxv_done) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
    if (abort_c) next_state = ST_IDLE;
  end

  // Next values for datapath and output registers.
  always_comb begin
    len_d        = len_q;
    rem_d        = rem_q;
    setn_d       = setn_q;
    cmd_d        = cmd_q;
`ifdef MXV_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    cmd_code_d   = cmd_code_q;
    cmd_valid_d  = 1'b0;
    n_size_d     = n_size_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    load_sel_d   = load_sel_q;
    start_d      = 1'b0;
    busy_d       = busy_q;
    frame_err_d  = abort_c;
    case (state)
      ST_LEN: if (bus.rx_valid) begin
        len_d = bus.rx_data;
`ifdef MXV_CHECKSUM_EN
        chk_d = bus.rx_data;
`endif
      end
      ST_CMD: if (bus.rx_valid) begin
        cmd_d = bus.rx_data[2:0];
        rem_d = len_q - DW'(1);
`ifdef MXV_CHECKSUM_EN
        chk_d = chk_q ^ bus.rx_data;
`endif
      end
      ST_PAYLOAD: if (bus.rx_valid && !expired) begin
        rem_d = rem_q - DW'(1);
`ifdef MXV_CHECKSUM_EN
        chk_d = chk_q ^ bus.rx_data;
`endif
        if (cmd_q == CMD_LOAD_M || cmd_q == CMD_LOAD_V) begin
          load_data_d  = bus.rx_data;
          load_valid_d = 1'b1;
          load_sel_d   = (cmd_q == CMD_LOAD_V);
        end
        if (cmd_q == CMD_SET_N) setn_d = bus.rx_data;
      end
      ST_WAIT_DONE: if (bus.mxv_done) busy_d = 1'b0;
      default: ;
    endcase
    if (next_state == ST_EXEC) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = cmd_q;
      if (cmd_q == CMD_SET_N) n_size_d = NW'(setn_q);
      if (cmd_q == CMD_COMPUTE) begin
        start_d = 1'b1;
        busy_d  = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q        <= '0;
      rem_q        <= '0;
      setn_q       <= '0;
      cmd_q        <= '0;
`ifdef MXV_CHECKSUM_EN
      chk_q        <= '0;
`endif
      cmd_code_q   <= '0;
      cmd_valid_q  <= 1'b0;
      n_size_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      load_sel_q   <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      len_q        <= len_d;
      rem_q        <= rem_d;
      setn_q       <= setn_d;
      cmd_q        <= cmd_d;
`ifdef MXV_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
      cmd_code_q   <= cmd_code_d;
      cmd_valid_q  <= cmd_valid_d;
      n_size_q     <= n_size_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      load_sel_q   <= load_sel_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.cmd_code   = cmd_code_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.n_size     = n_size_q;
  assign bus.load_data  = load_data_q;
  assign bus.load_valid = load_valid_q;
  assign bus.load_sel   = load_sel_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_mxv_cmd_sequencer.sv
// Directed table-driven bench for mxv_cmd_sequencer (default build, no checksum byte).
module tb_mxv_cmd_sequencer;
  import mxv_pkg::*;

  localparam int unsigned TO = 4096;

  logic clk, rst;
  mxv_cmd_sequencer_if bus();

  mxv_cmd_sequencer #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][7:0] b;
    int              nb;
    int              e_cv;
    logic [2:0]      e_code;
    int              e_fe;
    int              e_ld;
    logic            e_sel;
    logic [3:0]      e_n;
  } vec_t;

  vec_t vt[$];

  int n_cmp, n_bad;
  int cv_cnt, fe_cnt, st_cnt, ld_cnt, stuck;
  int cv_s, fe_s, st_s, ld_s;
  logic [2:0] last_code;
  logic [7:0] ld_data[256];
  logic       ld_sel[256];
  logic [3:0] prev;

  function automatic vec_t mk(input logic [63:0] bytes, input int nb, input int e_cv,
                              input logic [2:0] e_code, input int e_fe, input int e_ld,
                              input logic e_sel, input logic [3:0] e_n);
    vec_t v;
    v.b = bytes; v.nb = nb; v.e_cv = e_cv; v.e_code = e_code; v.e_fe = e_fe;
    v.e_ld = e_ld; v.e_sel = e_sel; v.e_n = e_n;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: sample all strobes on the falling edge.
  task automatic tick();
    logic [3:0] s;
    @(negedge clk);
    s = {bus.cmd_valid, bus.frame_err, bus.start, bus.load_valid};
    if ((s & prev) != 4'd0) stuck++;
    prev = s;
    if (bus.cmd_valid) begin cv_cnt++; last_code = bus.cmd_code; end
    if (bus.frame_err) fe_cnt++;
    if (bus.start) st_cnt++;
    if (bus.load_valid) begin
      ld_data[ld_cnt & 255] = bus.load_data;
      ld_sel[ld_cnt & 255]  = bus.load_sel;
      ld_cnt++;
    end
  endtask

  task automatic snap();
    cv_s = cv_cnt; fe_s = fe_cnt; st_s = st_cnt; ld_s = ld_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  // Bytes packed first-byte-most-significant within the low nb bytes.
  task automatic send_seq(input logic [63:0] bytes, input int nb);
    logic [7:0][7:0] bb;
    bb = bytes;
    for (int i = 0; i < nb; i++) send_byte(bb[nb-1-i]);
    repeat (4) tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    snap();
    send_seq(v.b, v.nb);
    chk($sformatf("v%0d cmd_valid", idx), cv_cnt - cv_s, v.e_cv);
    chk($sformatf("v%0d frame_err", idx), fe_cnt - fe_s, v.e_fe);
    chk($sformatf("v%0d load_count", idx), ld_cnt - ld_s, v.e_ld);
    chk($sformatf("v%0d start", idx), st_cnt - st_s, 0);
    chk($sformatf("v%0d n_size", idx), int'(bus.n_size), int'(v.e_n));
    chk($sformatf("v%0d busy", idx), int'(bus.busy), 0);
    if (v.e_cv > 0) chk($sformatf("v%0d cmd_code", idx), int'(last_code), int'(v.e_code));
    for (k = 0; k < v.e_ld && k < ld_cnt - ld_s; k++) begin
      chk($sformatf("v%0d load_data[%0d]", idx, k), int'(ld_data[(ld_s + k) & 255]),
          int'(v.b[v.nb - 4 - k]));
      chk($sformatf("v%0d load_sel[%0d]", idx, k), int'(ld_sel[(ld_s + k) & 255]), int'(v.e_sel));
    end
  endtask

  function automatic int all_outs();
    return int'({bus.cmd_code, bus.cmd_valid, bus.n_size, bus.load_data, bus.load_valid,
                 bus.load_sel, bus.start, bus.busy, bus.frame_err});
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0; cv_cnt = 0; fe_cnt = 0; st_cnt = 0; ld_cnt = 0; stuck = 0;
    prev = 4'd0; last_code = 3'd0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.mxv_done = 1'b0;
    rst = 1'b0;

    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h04, 8'h01, 8'hEF}), 5, 0, 3'd0, 1, 0, 1'b0, 4'd0));
    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF}), 5, 1, 3'd1, 0, 0, 1'b0, 4'd3));
    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}), 5, 1, 3'd1, 0, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h05, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF}), 8,
                    1, 3'd3, 0, 4, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h03, 8'h04, 8'h01, 8'h02, 8'hEF}), 6, 1, 3'd4, 0, 2, 1'b1, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h04, 8'h01, 8'hEF}), 5, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h03, 8'h03, 8'h01, 8'h02, 8'hEF}), 6, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h01, 8'h00, 8'hEF}), 5, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF}), 5, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h03, 8'h01, 8'h02, 8'h05, 8'hEF}), 6, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h00}), 2, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h01, 8'h07, 8'hEF}), 4, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h01, 8'h02, 8'hAA}), 4, 0, 3'd0, 1, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h01, 8'h02, 8'hEF}), 4, 1, 3'd2, 0, 0, 1'b0, 4'd2));
    vt.push_back(mk(64'({8'hFE, 8'h02, 8'h01, 8'h08, 8'hEF}), 5, 1, 3'd1, 0, 0, 1'b0, 4'd8));
    vt.push_back(mk(64'({8'hFE, 8'h04, 8'h03, 8'h01, 8'h02, 8'h03, 8'hEF}), 7,
                    0, 3'd0, 1, 0, 1'b0, 4'd8));
    vt.push_back(mk(64'({8'h11, 8'h22, 8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}), 7,
                    1, 3'd1, 0, 0, 1'b0, 4'd2));

    // Reset state
    repeat (2) tick();
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b1;
    repeat (2) tick();
    chk("post_reset_outputs", all_outs(), 0);

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Compute, frame dropped while busy, mxv_done, then RESEND
    snap();
    send_seq(64'({8'hFE, 8'h01, 8'h05, 8'hEF}), 4);
    chk("compute start", st_cnt - st_s, 1);
    chk("compute cmd_valid", cv_cnt - cv_s, 1);
    chk("compute cmd_code", int'(last_code), 5);
    chk("compute busy", int'(bus.busy), 1);
    snap();
    send_seq(64'({8'hFE, 8'h01, 8'h02, 8'hEF}), 4);
    chk("busy_drop cmd_valid", cv_cnt - cv_s, 0);
    chk("busy_drop frame_err", fe_cnt - fe_s, 0);
    chk("busy_drop busy", int'(bus.busy), 1);
    bus.mxv_done = 1'b1; tick(); bus.mxv_done = 1'b0; repeat (2) tick();
    chk("done busy", int'(bus.busy), 0);
    snap();
    send_seq(64'({8'hFE, 8'h01, 8'h02, 8'hEF}), 4);
    chk("resend cmd_valid", cv_cnt - cv_s, 1);
    chk("resend cmd_code", int'(last_code), 2);

    // Header byte coinciding with mxv_done is dropped
    send_seq(64'({8'hFE, 8'h01, 8'h05, 8'hEF}), 4);
    chk("compute2 busy", int'(bus.busy), 1);
    bus.rx_data = 8'hFE; bus.rx_valid = 1'b1; bus.mxv_done = 1'b1;
    tick();
    bus.rx_valid = 1'b0; bus.mxv_done = 1'b0;
    tick();
    chk("coincide busy", int'(bus.busy), 0);
    snap();
    send_seq(64'({8'h01, 8'h02, 8'hEF}), 3);
    chk("coincide dropped", cv_cnt - cv_s, 0);
    send_seq(64'({8'hFE, 8'h01, 8'h02, 8'hEF}), 4);
    chk("coincide recover", cv_cnt - cv_s, 1);

    // Inter-byte timeout
    send_seq(64'({8'hFE, 8'h02}), 2);
    snap();
    repeat (TO - 8) tick();
    chk("timeout early", fe_cnt - fe_s, 0);
    repeat (24) tick();
    chk("timeout fire", fe_cnt - fe_s, 1);
    snap();
    send_seq(64'({8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF}), 5);
    chk("timeout recover cmd_valid", cv_cnt - cv_s, 1);
    chk("timeout recover n_size", int'(bus.n_size), 4);

    // Asynchronous reset mid-frame
    send_seq(64'({8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}), 5);
    snap();
    send_seq(64'({8'hFE, 8'h05, 8'h03, 8'h0A, 8'h0B}), 5);
    chk("midframe loads", ld_cnt - ld_s, 2);
    chk("pre_reset load_data", int'(bus.load_data), 8'h0B);
    chk("pre_reset n_size", int'(bus.n_size), 2);
    #2 rst = 1'b0;
    #1;
    chk("async reset outputs", all_outs(), 0);
    chk("async reset n_size", int'(bus.n_size), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    snap();
    send_seq(64'({8'hFE, 8'h02, 8'h01, 8'h05, 8'hEF}), 5);
    chk("post reset cmd_valid", cv_cnt - cv_s, 1);
    chk("post reset n_size", int'(bus.n_size), 5);
    chk("post reset loads", ld_cnt - ld_s, 0);

    chk("strobe width", stuck, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mxv_cmd_sequencer.md
Name: mxv_cmd_sequencer

Overview:
- Frame parser and controller between the UART receive side and the matrix-by-vector (MxV) datapath.
- Consumes received bytes, validates the frame (header, length, command, payload, tail) and issues size, matrix-load, vector-load and compute commands to MxV.
- Holds off new frames while MxV computes.
- Drives the 3-bit command code exported on the top-level CMD_out.

Parameters:
- DW, 8, received byte width (from mxv_pkg).
- MAX_N, 8, largest legal matrix dimension N.
- TIMEOUT_CYC, 4096, idle clk cycles between bytes before a partial frame is aborted.

Ports:
- clk  in  1  system clock (baud-rate divided clock).
- rst  in  1  asynchronous active-low reset.
- rx_data  in  DW  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- mxv_done  in  1  one-cycle strobe, MxV finished and results queued for Tx.
- cmd_code  out  3  last decoded command.
- cmd_valid  out  1  one-cycle strobe with cmd_code.
- n_size  out  4  registered dimension N.
- load_data  out  DW  payload byte to MxV FIFOs.
- load_valid  out  1  one-cycle strobe with load_data.
- load_sel  out  1  0 = matrix FIFO, 1 = vector FIFO.
- start  out  1  one-cycle compute start.
- busy  out  1  high from start until mxv_done.
- frame_err  out  1  one-cycle strobe on any rejected frame.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; n_size = 0; counters cleared.
- Frame format: 0xFE, LEN, CMD, LEN-1 payload bytes, 0xEF. LEN counts CMD plus payload.
- Command codes:
  - 1: SET_N. 1 payload byte, legal range 1..MAX_N.
  - 2: RESEND. 0 payload bytes.
  - 3: LOAD_MATRIX. Payload is N*N bytes.
  - 4: LOAD_VECTOR. Payload is N bytes.
  - 5: COMPUTE. 0 payload bytes.
- FSM states, advanced only on rx_valid except WAIT_DONE:
  - IDLE: 0xFE -> LEN; any other byte is ignored.
  - LEN: LEN = 0 -> frame_err, IDLE; otherwise latch LEN -> CMD.
  - CMD: latch CMD, remaining = LEN-1. remaining > 0 -> PAYLOAD, else -> TAIL.
  - PAYLOAD: for LOAD commands, forward each byte the next cycle as load_data/load_valid with load_sel set. For SET_N, latch the byte. Decrement remaining; at 0 -> TAIL.
  - TAIL: 0xEF -> EXEC; any other byte -> frame_err, IDLE.
  - EXEC (one cycle):
    - Pulse cmd_valid with cmd_code = CMD.
    - SET_N commits n_size.
    - COMPUTE pulses start, sets busy -> WAIT_DONE.
    - All other commands -> IDLE.
  - WAIT_DONE: rx_valid bytes are dropped. mxv_done clears busy -> IDLE.
- Length checks, done in CMD before any payload forwarding; any failure -> frame_err, IDLE:
  - LOAD_MATRIX requires LEN-1 = n_size*n_size (8-bit product).
  - LOAD_VECTOR requires LEN-1 = n_size.
  - SET_N requires LEN = 2.
  - Loads with n_size = 0 are rejected.
  - An unknown CMD is rejected.
- Bad SET_N value: a payload of 0 or > MAX_N gives frame_err at TAIL and leaves n_size unchanged.
- Timeout: in LEN/CMD/PAYLOAD/TAIL a counter runs; it resets on every rx_valid. Reaching TIMEOUT_CYC -> frame_err, IDLE. Bytes already forwarded are not retracted.
- Simultaneous events:
  - rx_valid in the same cycle as mxv_done in WAIT_DONE: the byte is dropped, the state goes to IDLE.
  - mxv_done outside WAIT_DONE is ignored.
- frame_err, cmd_valid, load_valid and start are never high for more than one cycle.
- Reset mid-frame aborts immediately; n_size returns to 0.

Optional Feature:
- Macro MXV_CHECKSUM_EN.
- Enabled:
  - A CHK byte sits between the payload and 0xEF: the XOR of LEN, CMD and all payload bytes.
  - Extra state CHK follows PAYLOAD (or CMD when there is no payload).
  - A mismatch -> frame_err, IDLE, with no cmd_valid or start. Load bytes already forwarded still stand.
- Disabled: no CHK state; the frame format is as above.

Decomposition:
- mxv_pkg holds:
  - DW and MAX_N.
  - Header/tail constants HDR = 8'hFE and TAIL = 8'hEF.
  - cmd_e enum: CMD_SET_N = 1, CMD_RESEND = 2, CMD_LOAD_M = 3, CMD_LOAD_V = 4, CMD_COMPUTE = 5.
  - seq_state_e enum.
- One sub-module, mxv_rx_timeout: an inter-byte watchdog counter with inputs clr and en, and output expired.

Test Plan:
- SET_N: FE 02 01 03 EF -> one cmd_valid with cmd_code = 1; n_size = 3; no frame_err.
- Matrix load, n_size = 2: FE 05 03 0A 0B 0C 0D EF -> 4 load_valid pulses carrying 0A 0B 0C 0D, each with load_sel = 0; then cmd_valid with code 3.
- Bad length, n_size = 2: FE 03 04 01 02 EF (vector needs 2 bytes, this gives 2 — legal). Then FE 02 04 01 EF -> frame_err at CMD; no load_valid pulses.
- Compute: FE 01 05 EF -> start pulse; busy high. Bytes FE 01 02 EF sent while busy are ignored. mxv_done -> busy low; a subsequent RESEND frame decodes.
- Timeout: FE 02, then TIMEOUT_CYC cycles with no rx_valid -> one frame_err; back in IDLE; the next FE 02 01 04 EF sets n_size = 4.
- Bad tail and mid-frame reset: FE 01 02 AA -> frame_err. Then FE 05 03 plus 2 bytes, then rst low -> all outputs 0 and n_size = 0 asynchronously.
